// File: rtl/motor_mixer_if.sv
// ============================================================================
// Module      : motor_mixer_if
// Description : Host command and ramp dispatch signals for the X-quad mixer.
//               The master side is the flight controller plus the four ramps.
//               The slave side is the mixer itself.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface motor_mixer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        arm;
    logic [15:0] throttle;
    logic [15:0] roll;
    logic [15:0] pitch;
    logic [15:0] yaw;
    logic [3:0]  pwm_busy;
    logic [63:0] speed_out;
    logic [3:0]  speed_oe;
    logic        done;
    logic        timeout_err;

    modport master (
        output cmd_valid, arm, throttle, roll, pitch, yaw, pwm_busy,
        input  cmd_ready, speed_out, speed_oe, done, timeout_err
    );

    modport slave (
        input  cmd_valid, arm, throttle, roll, pitch, yaw, pwm_busy,
        output cmd_ready, speed_out, speed_oe, done, timeout_err
    );
endinterface

`default_nettype wire

// File: rtl/motor_mixer.sv
// ============================================================================
// Module      : motor_mixer
// Description : Mixes one flight command (throttle, roll, pitch, yaw) into four
//               clamped X-quad motor speeds. One motor is mixed per cycle, and
//               all four share a single adder path. Each speed is then handed
//               to its PWM ramp with a one-cycle strobe. A strobe is issued only
//               while that ramp is not busy, and undelivered speeds are dropped
//               after a bounded wait.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module motor_mixer #(
    parameter int MIN_SPEED   = 256,
    parameter int MAX_OUT     = 65535,
    parameter int TIMEOUT_CYC = 20000
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    motor_mixer_if.slave   bus
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [15:0]       c_min_speed = 16'(MIN_SPEED);
    localparam logic [15:0]       c_max_out   = 16'(MAX_OUT);
    localparam logic signed [18:0] c_min_s    = $signed({3'b000, c_min_speed});
    localparam logic signed [18:0] c_max_s    = $signed({3'b000, c_max_out});
    localparam logic [CNT_W-1:0]  c_tout_last = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MIX      = 2'd1,
        S_DISPATCH = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        k_q, k_d;
    logic [15:0]       thr_q, thr_d;
    logic [15:0]       roll_q, roll_d;
    logic [15:0]       pitch_q, pitch_d;
    logic [15:0]       yaw_q, yaw_d;
    logic              arm_q, arm_d;
    logic [3:0][15:0]  lane_q, lane_d;
    logic [3:0]        pend_q, pend_d;
    logic [CNT_W-1:0]  tcnt_q, tcnt_d;
    logic [3:0]        oe_q, oe_d;
    logic              done_q, done_d;
    logic              terr_q, terr_d;

    logic signed [18:0] w_t, w_r, w_p, w_y;
    logic signed [18:0] w_rs, w_ps, w_ys, w_sum;
    logic [15:0]        w_speed;
    logic [3:0]         w_pend_left;

    // Shared mixer: choose the correction signs for motor k_q, add once, then clamp.
    always_comb begin
        w_t = $signed({3'b000, thr_q});
        w_r = $signed({{3{roll_q[15]}},  roll_q});
        w_p = $signed({{3{pitch_q[15]}}, pitch_q});
        w_y = $signed({{3{yaw_q[15]}},   yaw_q});
        // Pitch is negative for the rear motors (2, 3).
        w_ps = k_q[1] ? -w_p : w_p;
        // Roll is negative for the right-side motors (1, 2).
        w_rs = (k_q == 2'd1 || k_q == 2'd2) ? -w_r : w_r;
        // Yaw is negative for motors 0 and 2, which spin in the same direction.
        w_ys = (k_q == 2'd0 || k_q == 2'd2) ? -w_y : w_y;
        w_sum = w_t + w_ps + w_rs + w_ys;
        if (!arm_q || w_sum < c_min_s) begin
            w_speed = c_min_speed;
        end else if (w_sum > c_max_s) begin
            w_speed = c_max_out;
        end else begin
            w_speed = w_sum[15:0];
        end
    end

    // Next-state logic for the IDLE -> MIX -> DISPATCH sequence.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        thr_d       = thr_q;
        roll_d      = roll_q;
        pitch_d     = pitch_q;
        yaw_d       = yaw_q;
        arm_d       = arm_q;
        lane_d      = lane_q;
        pend_d      = pend_q;
        tcnt_d      = tcnt_q;
        oe_d        = 4'b0000;
        done_d      = 1'b0;
        terr_d      = terr_q;
        w_pend_left = pend_q & bus.pwm_busy;

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    thr_d   = bus.throttle;
                    roll_d  = bus.roll;
                    pitch_d = bus.pitch;
                    yaw_d   = bus.yaw;
                    arm_d   = bus.arm;
                    k_d     = 2'd0;
                    state_d = S_MIX;
                end
            end
            S_MIX: begin
                lane_d[k_q] = w_speed;
                k_d         = k_q + 2'd1;
                if (k_q == 2'd3) begin
                    pend_d  = 4'b1111;
                    tcnt_d  = '0;
                    state_d = S_DISPATCH;
                end
            end
            S_DISPATCH: begin
                if (pend_q == 4'b0000) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    // Strobe every motor whose ramp is free this cycle.
                    oe_d   = pend_q & ~bus.pwm_busy;
                    pend_d = w_pend_left;
                    tcnt_d = tcnt_q + CNT_W'(1);
                    // Give up on motors whose ramps stay busy too long. Their lanes keep the new value.
                    if (tcnt_q >= c_tout_last && w_pend_left != 4'b0000) begin
                        pend_d  = 4'b0000;
                        terr_d  = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers. Every lane resets to the disarmed speed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            k_q     <= 2'd0;
            thr_q   <= 16'd0;
            roll_q  <= 16'd0;
            pitch_q <= 16'd0;
            yaw_q   <= 16'd0;
            arm_q   <= 1'b0;
            lane_q  <= {4{c_min_speed}};
            pend_q  <= 4'b0000;
            tcnt_q  <= '0;
            oe_q    <= 4'b0000;
            done_q  <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            thr_q   <= thr_d;
            roll_q  <= roll_d;
            pitch_q <= pitch_d;
            yaw_q   <= yaw_d;
            arm_q   <= arm_d;
            lane_q  <= lane_d;
            pend_q  <= pend_d;
            tcnt_q  <= tcnt_d;
            oe_q    <= oe_d;
            done_q  <= done_d;
            terr_q  <= terr_d;
        end
    end

    assign bus.cmd_ready   = (state_q == S_IDLE);
    assign bus.speed_out   = lane_q;
    assign bus.speed_oe    = oe_q;
    assign bus.done        = done_q;
    assign bus.timeout_err = terr_q;

endmodule

`default_nettype wire

// File: tb/tb_motor_mixer.sv
// ============================================================================
// Module      : tb_motor_mixer
// Description : Scoreboard bench for motor_mixer. Directed commands push their
//               hand-computed lane values into a queue. A monitor checks every
//               strobe and every done pulse against the head of that queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_motor_mixer;

    localparam int TOUT = 200;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    motor_mixer_if bus ();

    motor_mixer #(
        .MIN_SPEED   (256),
        .MAX_OUT     (65535),
        .TIMEOUT_CYC (TOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [63:0] lanes;
        logic [3:0]  mask;
        logic        terr;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic logic [63:0] L(input int m0, input int m1, input int m2, input int m3);
        return {16'(m3), 16'(m2), 16'(m1), 16'(m0)};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic report(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s", name);
    endtask

    // Monitor: check strobed lanes, repeated strobes, and the final state at done.
    logic [3:0] got_mask = 4'b0000;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                got_mask = 4'b0000;
            end else begin
                if (bus.speed_oe != 4'b0000) begin
                    if (exp_q.size() == 0) begin
                        report($sformatf("oe_without_cmd oe=%b", bus.speed_oe));
                    end else begin
                        chk("oe_repeat", 64'(got_mask & bus.speed_oe), 64'd0);
                        for (int i = 0; i < 4; i++) begin
                            if (bus.speed_oe[i]) begin
                                chk($sformatf("oe_lane%0d", i), 64'(bus.speed_out[16*i +: 16]),
                                    64'(exp_q[0].lanes[16*i +: 16]));
                            end
                        end
                        got_mask = got_mask | bus.speed_oe;
                    end
                end
                if (bus.done) begin
                    if (exp_q.size() == 0) begin
                        report("done_without_cmd");
                    end else begin
                        e = exp_q.pop_front();
                        chk("oe_mask_at_done", 64'(got_mask), 64'(e.mask));
                        chk("timeout_err_at_done", 64'(bus.timeout_err), 64'(e.terr));
                        chk("lanes_at_done", bus.speed_out, e.lanes);
                    end
                    got_mask = 4'b0000;
                end
            end
        end
    end

    // Issue one command and measure strobe/done latency relative to the accept edge.
    task automatic run_cmd(input string nm,
                           input logic [15:0] t, input logic [15:0] r,
                           input logic [15:0] p, input logic [15:0] y, input logic a,
                           input logic [3:0] busy0, input int rel_cyc, input logic [3:0] rel_mask,
                           input logic spur, input logic [63:0] lanes, input logic [3:0] mask,
                           input logic terr, input logic [3:0] first_mask,
                           input int lat_oe, input int lat_done);
        exp_t       e;
        int         c;
        int         got_oe   = -1;
        int         got_done = -1;
        logic [3:0] fm       = 4'b0000;
        bus.pwm_busy = busy0;
        c = 0;
        @(negedge clk);
        while (!bus.cmd_ready && c < 100) begin
            @(negedge clk);
            c++;
        end
        if (!bus.cmd_ready) begin
            report($sformatf("%s_ready_wait_expired", nm));
        end
        e.lanes = lanes;
        e.mask  = mask;
        e.terr  = terr;
        exp_q.push_back(e);
        bus.throttle  = t;
        bus.roll      = r;
        bus.pitch     = p;
        bus.yaw       = y;
        bus.arm       = a;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        for (c = 1; c <= TOUT + 50; c++) begin
            @(posedge clk);
            #1;
            if (got_oe < 0 && bus.speed_oe != 4'b0000) begin
                got_oe = c;
                fm     = bus.speed_oe;
            end
            if (bus.done) begin
                got_done = c;
                break;
            end
            if (c == rel_cyc) bus.pwm_busy = bus.pwm_busy & ~rel_mask;
            if (spur) begin
                if (c >= 6 && c <= 9) begin
                    chk($sformatf("%s_ready_low_in_dispatch", nm), 64'(bus.cmd_ready), 64'd0);
                    bus.cmd_valid = 1'b1;
                    bus.throttle  = 16'd1234;
                    bus.arm       = 1'b1;
                end else if (c == 10) begin
                    bus.cmd_valid = 1'b0;
                end
            end
        end
        chk($sformatf("%s_oe_latency", nm), 64'(got_oe), 64'(lat_oe));
        chk($sformatf("%s_first_oe", nm), 64'(fm), 64'(first_mask));
        chk($sformatf("%s_done_latency", nm), 64'(got_done), 64'(lat_done));
        bus.pwm_busy = 4'b0000;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.arm       = 1'b0;
        bus.throttle  = 16'd0;
        bus.roll      = 16'd0;
        bus.pitch     = 16'd0;
        bus.yaw       = 16'd0;
        bus.pwm_busy  = 4'b0000;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_oe", 64'(bus.speed_oe), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_terr", 64'(bus.timeout_err), 64'd0);
        chk("rst_lanes", bus.speed_out, L(256, 256, 256, 256));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_ready_after_release", 64'(bus.cmd_ready), 64'd1);

        // Straight throttle: all four strobes five cycles after accept, done one cycle later.
        run_cmd("flat", 16'd30000, 16'd0, 16'd0, 16'd0, 1'b1, 4'b0000, 0, 4'b0000, 1'b0,
                L(30000, 30000, 30000, 30000), 4'b1111, 1'b0, 4'b1111, 5, 6);
        // Mixed corrections with R=+1000, P=-500, Y=+200.
        run_cmd("mix", 16'd30000, 16'd1000, 16'hFE0C, 16'd200, 1'b1, 4'b0000, 0, 4'b0000, 1'b0,
                L(30300, 28700, 29300, 31700), 4'b1111, 1'b0, 4'b1111, 5, 6);
        // Upper clamp on motor 0.
        run_cmd("clamp_hi", 16'd65000, 16'd2000, 16'd2000, 16'hF830, 1'b1, 4'b0000, 0, 4'b0000, 1'b0,
                L(65535, 63000, 63000, 63000), 4'b1111, 1'b0, 4'b1111, 5, 6);
        // Lower clamp with R=P=-2000. Motor 2 lands at 4100 without clamping.
        run_cmd("clamp_lo", 16'd100, 16'hF830, 16'hF830, 16'd0, 1'b1, 4'b0000, 0, 4'b0000, 1'b0,
                L(256, 256, 4100, 256), 4'b1111, 1'b0, 4'b1111, 5, 6);
        // Disarmed: every lane is forced to the minimum speed.
        run_cmd("disarm", 16'd40000, 16'd1000, 16'd1000, 16'd1000, 1'b0, 4'b0000, 0, 4'b0000, 1'b0,
                L(256, 256, 256, 256), 4'b1111, 1'b0, 4'b1111, 5, 6);
        // Most-negative corrections exercise sign extension and both clamps.
        run_cmd("extreme", 16'd0, 16'h8000, 16'h8000, 16'h8000, 1'b1, 4'b0000, 0, 4'b0000, 1'b0,
                L(256, 256, 65535, 256), 4'b1111, 1'b0, 4'b1111, 5, 6);
        // One below the minimum clamps; values above it pass through.
        run_cmd("edge_min", 16'd300, 16'd45, 16'd0, 16'd0, 1'b1, 4'b0000, 0, 4'b0000, 1'b0,
                L(345, 256, 256, 345), 4'b1111, 1'b0, 4'b1111, 5, 6);
        // All ramps busy. A second command is offered mid-dispatch and must be ignored.
        run_cmd("spurious", 16'd12000, 16'hFF9C, 16'd300, 16'hFFCE, 1'b1, 4'b1111, 12, 4'b1111, 1'b1,
                L(12250, 12350, 11850, 11550), 4'b1111, 1'b0, 4'b1111, 13, 14);
        // Ramps 0 and 2 busy. Ramp 0 frees ten cycles after the first strobes; ramp 2 times out.
        run_cmd("busy_tout", 16'd30000, 16'd1000, 16'hFE0C, 16'd200, 1'b1, 4'b0101, 15, 4'b0001, 1'b0,
                L(30300, 28700, 29300, 31700), 4'b1011, 1'b1, 4'b1010, 5, TOUT + 4);
        @(posedge clk);
        #1;
        chk("terr_sticky", 64'(bus.timeout_err), 64'd1);
        chk("ready_after_timeout", 64'(bus.cmd_ready), 64'd1);

        // Reset mid-MIX aborts the command and clears the sticky error.
        @(negedge clk);
        bus.throttle  = 16'd50000;
        bus.roll      = 16'd0;
        bus.pitch     = 16'd0;
        bus.yaw       = 16'd0;
        bus.arm       = 1'b1;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midmix_rst_oe", 64'(bus.speed_oe), 64'd0);
        chk("midmix_rst_lanes", bus.speed_out, L(256, 256, 256, 256));
        chk("midmix_rst_terr", 64'(bus.timeout_err), 64'd0);
        chk("midmix_rst_done", 64'(bus.done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midmix_ready_after_release", 64'(bus.cmd_ready), 64'd1);
        repeat (8) @(posedge clk);
        #1;
        chk("midmix_no_oe", 64'(bus.speed_oe), 64'd0);

        // Normal operation after reset, with the error flag cleared.
        run_cmd("post_rst", 16'd30000, 16'd0, 16'd0, 16'd0, 1'b1, 4'b0000, 0, 4'b0000, 1'b0,
                L(30000, 30000, 30000, 30000), 4'b1111, 1'b0, 4'b1111, 5, 6);

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
